sseg_scan_ctrl: RTL
===================

# sseg_scan_ctrl

Scan controller for the 8-digit, active-low seven-segment display on the board. It owns the refresh prescaler and the digit index, and holds a double-buffered digit store. Writers update a shadow buffer through a valid/ready port; an atomic commit copies it to the active buffer only at a frame boundary, so a frame never shows a mix of old and new digits. It also drives the anode enables with per-digit blanking and global PWM brightness, replacing free-running counter-slice multiplexing in the top level.

## Interface
- `DIGITS`, 8, number of digits scanned; index width is `$clog2(DIGITS)`.
- `PRESCALE`, 12500, clocks per digit slot (100 MHz gives 8 kHz slots and a 1 kHz frame); must be ≥ 2.
- `BRIGHT_W`, 4, width of the brightness control and PWM counter.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_valid`  in  1  shadow write request.
- `wr_ready`  out  1  shadow port accepting writes and commits.
- `wr_idx`  in  `$clog2(DIGITS)`  digit to write.
- `wr_data`  in  8  active-low segment pattern, {dp,g..a}.
- `commit`  in  1  request shadow-to-active copy at the next frame boundary.
- `commit_done`  out  1  one-cycle pulse when the copy happens.
- `blank_mask`  in  DIGITS  bit i = 1 forces digit i dark.
- `bright`  in  BRIGHT_W  duty control; duty = (bright+1)/2^BRIGHT_W.
- `an`  out  DIGITS  active-low anode enables.
- `sseg`  out  8  active-low segments.
- `frame_start`  out  1  one-cycle pulse when the digit index wraps to 0.

## Operation
- **Slot counter `slot_cnt`**
  - Counts 0..PRESCALE-1.
  - At PRESCALE-1 it returns to 0 and `idx` advances; `idx` wraps DIGITS-1 → 0.
- **Frame boundary:** the edge where `idx` goes DIGITS-1 → 0.
- **PWM**
  - Free-running BRIGHT_W-bit counter `pwm_cnt`.
  - `pwm_on` = (`pwm_cnt` ≤ `bright`).
  - All-ones `bright` gives 100% duty.
- **Shadow writes**
  - `wr_valid && wr_ready` writes `shadow[wr_idx]` at the next edge.
  - `wr_idx` ≥ DIGITS is accepted and discarded.
- **Commit FSM, states IDLE and PENDING**
  - IDLE → PENDING on `commit && wr_ready`.
  - A write in the same cycle is included in the copy.
  - PENDING → IDLE at the frame boundary: `active` ← `shadow`, and `commit_done` pulses in the same cycle as `frame_start`.
  - `wr_ready` = 1 only in IDLE. In PENDING, writes and commits are ignored.
  - If `commit` is accepted in a frame-boundary cycle, the copy happens at the following boundary, not the current one.
- **Drive**
  - `an[i]` = 0 iff i == `idx` && !`blank_mask[i]` && `pwm_on`.
  - `sseg` = `active[idx]` when the current digit is enabled; otherwise 8'hFF.

## Timing
- **Outputs:** `an`, `sseg`, `frame_start` and `commit_done` are registered.
  - `an` and `sseg` lag `idx`/`pwm_cnt` by one cycle.
  - `blank_mask` and `bright` changes reach `an` after 1 cycle.
- **Reset values:**
  - `an` = all 1s, `sseg` = 8'hFF, `frame_start` = 0, `commit_done` = 0, `wr_ready` = 1.
  - `slot_cnt`, `idx` and `pwm_cnt` = 0.
  - Shadow and active buffers = 8'hFF; FSM = IDLE.
- **Reset mid-commit:** the pending commit is dropped, with no copy and no `commit_done`.
- **Frame period:** DIGITS×PRESCALE clocks. `frame_start` first pulses DIGITS×PRESCALE clocks after reset release.
- **Commit latency:** from acceptance to `commit_done`, 1 to DIGITS×PRESCALE clocks.

## Configuration
- **Macro `SSEG_BLINK_EN`**
  - **Defined:**
    - Adds parameter `BLINK_FRAMES` (default 250) and input `blink_mask` [DIGITS].
    - A frame counter toggles `blink_phase` every BLINK_FRAMES frame boundaries; `blink_phase` resets to 0 (visible).
    - While `blink_phase` = 1, digits with `blink_mask[i]` = 1 are dark, same as blanked.
  - **Undefined:** port, parameter, counter and blink gating are absent; behaviour is exactly as above.

## Test plan
Bench uses DIGITS=8, PRESCALE=4, BRIGHT_W=4.
- **Reset and scan:** release reset, `bright`=15, `blank_mask`=0.
  - `an` = 8'hFE for 4 cycles, then 8'hFD, …, 8'h7F.
  - `frame_start` at clock 32; `sseg` = 8'hFF throughout.
- **Write and commit:** write digit 3 = 8'hC0, assert `commit` mid-frame.
  - `wr_ready` = 0 until the boundary; `commit_done` coincides with `frame_start`.
  - In the next frame, `sseg` = 8'hC0 only while `an` = 8'hF7.
- **Write during PENDING:** write digit 0 = 8'hA4 while pending.
  - Ignored; digit 0 stays 8'hFF after the commit.
- **Brightness:** `bright`=3.
  - Selected anode is low exactly 4 of every 16 clocks; `sseg` = 8'hFF when the anode is high.
- **Blank and boundaries:**
  - `blank_mask`=8'h04 → `an[2]` never low.
  - `commit` asserted in the `frame_start` cycle → `commit_done` one full frame (32 clocks) later.
  - `rst` in PENDING → no `commit_done`, active buffer unchanged.
- **Blink (`SSEG_BLINK_EN`):** `BLINK_FRAMES`=2, `blink_mask`=8'h01.
  - Digit 0 is lit for 2 frames, dark for 2 frames, repeating.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a double-buffered digit store,
// frame-aligned atomic commit, per-digit blanking and PWM brightness. Optional blink: SSEG_BLINK_EN.
module sseg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 12500,
  parameter int BRIGHT_W     = 4
`ifdef SSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(DIGITS)-1:0]   wr_idx,
  input  logic [7:0]                  wr_data,
  input  logic                        commit,
  output logic                        commit_done,
  input  logic [DIGITS-1:0]           blank_mask,
`ifdef SSEG_BLINK_EN
  input  logic [DIGITS-1:0]           blink_mask,
`endif
  input  logic [BRIGHT_W-1:0]         bright,
  output logic [DIGITS-1:0]           an,
  output logic [7:0]                  sseg,
  output logic                        frame_start
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int SLOT_W = $clog2(PRESCALE);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef enum logic {
    IDLE,
    PENDING
  } commit_state_t;

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic                slot_last;
  logic                frame_wrap;

  logic [7:0]          shadow [DIGITS];
  logic [7:0]          active [DIGITS];

  commit_state_t       state, state_nxt;
  logic                wr_fire;
  logic                wr_idx_ok;
  logic                do_copy;

  logic [DIGITS-1:0]   dark_mask;
  logic                pwm_on;
  logic                lit;
  logic [DIGITS-1:0]   an_nxt;
  logic [7:0]          sseg_nxt;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_last && (idx == IDX_LAST);

  // Scan timing: slot prescaler, digit index and free-running PWM counter.
  always_ff @(posedge clk) begin
    // NOTE: every sequential block uses non-blocking assignments so all registers update together.
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  assign wr_ready  = (state == IDLE);
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_idx_ok = (int'(wr_idx) < DIGITS);
  assign do_copy   = (state == PENDING) && frame_wrap;

  always_ff @(posedge clk) begin
    if (state_nxt == IDLE || state_nxt == PENDING) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the block leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (commit)     state_nxt = PENDING;
      PENDING: if (frame_wrap) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both buffers are reset so the display comes up blank rather than showing garbage.
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= 8'hFF;
        active[i] <= 8'hFF;
      end
    end else begin
      if (wr_fire && wr_idx_ok) shadow[wr_idx] <= wr_data;
      if (do_copy) begin
        for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
      end
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0] blink_cnt;
  logic            blink_phase;

  // Phase flips after every BLINK_FRAMES frame boundaries; phase 1 darkens blink_mask digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == BF_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign dark_mask = blank_mask | (blink_phase ? blink_mask : '0);
`else
  assign dark_mask = blank_mask;
`endif

  assign pwm_on = (pwm_cnt <= bright);
  assign lit    = pwm_on && !dark_mask[idx];

  always_comb begin
    an_nxt   = '1;
    sseg_nxt = 8'hFF;
    if (lit) begin
      an_nxt[idx] = 1'b0;
      sseg_nxt    = active[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= '1;
      sseg        <= 8'hFF;
      frame_start <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      an          <= an_nxt;
      sseg        <= sseg_nxt;
      frame_start <= frame_wrap;
      commit_done <= do_copy;
    end
  end

endmodule
